// File: rtl/aes_pkg.sv
// Shared AES constants and helpers for the encrypt and decrypt cores.
// Byte 0 of a 128-bit block sits at [127:120]; blocks are column-major.
package aes_pkg;

  localparam int NB        = 16;
  localparam int NR_AES128 = 10;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_state_e;

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] r;
    case (rnd)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes a0..a3 run top row to bottom row, a0 in the MSBs.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] blk, input int idx);
    return blk[127-8*idx -: 8];
  endfunction

  function automatic logic [31:0] get_word(input logic [127:0] blk, input int idx);
    return blk[127-32*idx -: 32];
  endfunction

endpackage

// File: rtl/aes_encrypt_iter_if.sv
// Block-in / block-out handshake bundle for the iterative AES encrypt core.
interface aes_encrypt_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plain_text;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] cipher_text;

  modport master (output in_valid, plain_text, key, out_ready,
                  input  in_ready, out_valid, cipher_text);
  modport slave  (input  in_valid, plain_text, key, out_ready,
                  output in_ready, out_valid, cipher_text);
endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, combinational; one row constant per high nibble.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [127:0] row;

  always_comb begin
    row = '0;
    case (a[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
      default: row = '0;
    endcase
  end

  assign y = row[127-8*a[3:0] -: 8];
endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encrypt: one full round per clock, round keys expanded
// on the fly alongside the data path.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic              clk,
  input  logic              rst_n,
  aes_encrypt_iter_if.slave bus,
  output logic              busy
);

  if (NR != NR_AES128) begin : g_bad_nr
    $error("aes_encrypt_iter: only NR = 10 (AES-128) is supported");
  end

  localparam logic [3:0] NR_L = 4'(NR);

  aes_state_e   fsm_q;
  logic [127:0] state_q, rk_q, ct_q;
  logic [3:0]   rnd_q;
  logic         ov_q, busy_q;

  // Data path: SubBytes -> ShiftRows -> MixColumns
  logic [NB-1:0][7:0] sb;
  logic [127:0]       sr_blk, mc_blk, rnd_res;

  for (genvar i = 0; i < NB; i++) begin : g_sub
    aes_sbox u_sbox (.a(get_byte(state_q, i)), .y(sb[i]));
  end

  // Row r rotates left by r: out(r,c) takes in(r,(c+r)%4).
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr_blk[127-8*(r+4*c) -: 8] = sb[r+4*((c+r)%4)];
    end
    assign mc_blk[127-32*c -: 32] = mix_column(sr_blk[127-32*c -: 32]);
  end

  // Key schedule: next round key from the current one
  logic [31:0]  w3, rot, sw, w0n, w1n, w2n, w3n;
  logic [127:0] rk_n;

  assign w3  = get_word(rk_q, 3);
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_ksub
    aes_sbox u_ksbox (.a(rot[31-8*j -: 8]), .y(sw[31-8*j -: 8]));
  end

  assign w0n  = get_word(rk_q, 0) ^ sw ^ {rcon(rnd_q), 24'h0};
  assign w1n  = get_word(rk_q, 1) ^ w0n;
  assign w2n  = get_word(rk_q, 2) ^ w1n;
  assign w3n  = w3 ^ w2n;
  assign rk_n = {w0n, w1n, w2n, w3n};

  // Final round skips MixColumns.
  assign rnd_res = ((rnd_q == NR_L) ? sr_blk : mc_blk) ^ rk_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
      ct_q    <= '0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: if (bus.in_valid) begin
          state_q <= bus.plain_text ^ bus.key;
          rk_q    <= bus.key;
          rnd_q   <= 4'd1;
          busy_q  <= 1'b1;
          fsm_q   <= ROUND;
        end
        ROUND: begin
          state_q <= rnd_res;
          rk_q    <= rk_n;
          rnd_q   <= rnd_q + 4'd1;
          if (rnd_q == NR_L) begin
            ct_q  <= rnd_res;
            ov_q  <= 1'b1;
            fsm_q <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          ov_q   <= 1'b0;
          busy_q <= 1'b0;
          fsm_q  <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (fsm_q == IDLE);
  assign bus.out_valid   = ov_q;
  assign bus.cipher_text = ct_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Randomised bench for aes_encrypt_iter against a byte-array AES-128 model
// whose S-box is derived from GF(2^8) inversion plus the affine transform.
module tb_aes_encrypt_iter;

  logic clk, rst_n, busy;
  aes_encrypt_iter_if bus();

  aes_encrypt_iter #(.NR(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R1B = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, b;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      b = inv;
      sbox_t[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                    ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_model(input logic [127:0] k, input logic [127:0] p);
    logic [7:0] w [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] t0, t1, t2, t3, tmp, rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      w[i] = k[127-8*i -: 8];
      s[i] = p[127-8*i -: 8] ^ w[i];
    end
    for (int i = 4; i < 44; i++) begin
      t0 = w[4*i-4]; t1 = w[4*i-3]; t2 = w[4*i-2]; t3 = w[4*i-1];
      if (i % 4 == 0) begin
        tmp = t0;
        t0 = sbox_t[t1] ^ rc; t1 = sbox_t[t2]; t2 = sbox_t[t3]; t3 = sbox_t[tmp];
        rc = gmul(rc, 8'h02);
      end
      w[4*i]   = w[4*i-16] ^ t0;
      w[4*i+1] = w[4*i-15] ^ t1;
      w[4*i+2] = w[4*i-14] ^ t2;
      w[4*i+3] = w[4*i-13] ^ t3;
    end
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) s[rw+4*c] = t[rw+4*((c+rw)%4)];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
          s[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
        end
      for (int i = 0; i < 16; i++) s[i] ^= w[16*r+i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- cycle monitor ----------------
  int           cyc = 0;
  logic         outst = 1'b0;
  int           acc_edge = 0;
  int           n_acc = 0;
  logic [127:0] last_ct = '0;
  logic [127:0] exp_q [$];
  int           acc_times [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic exp_ov;
    if (!rst_n) begin
      outst = 1'b0;
      exp_q.delete();
      last_ct = '0;
      chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
      chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_cipher_text", bus.cipher_text, '0);
    end else begin
      exp_ov = outst && (cyc >= acc_edge + 10);
      chk("in_ready", 128'(bus.in_ready), 128'(!outst));
      chk("busy", 128'(busy), 128'(outst));
      chk("out_valid", 128'(bus.out_valid), 128'(exp_ov));
      chk("cipher_text", bus.cipher_text, exp_ov ? exp_q[0] : last_ct);
      if (exp_ov && bus.out_ready) begin
        last_ct = exp_q.pop_front();
        outst = 1'b0;
      end else if (!outst && bus.in_valid) begin
        outst = 1'b1;
        acc_edge = cyc + 1;
        acc_times.push_back(cyc + 1);
        exp_q.push_back(aes_model(bus.key, bus.plain_text));
        n_acc++;
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_ov(output int n);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("out_valid_timeout", 128'(0), 128'(1));
  endtask

  // Presents one block for a single cycle; core must be idle on entry.
  task automatic send(input logic [127:0] k, input logic [127:0] p);
    bus.key = k; bus.plain_text = p; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int n, target, guard;
    build_sbox();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.plain_text = '0; bus.key = '0;

    chk("model_c1", aes_model(K1, P1), C1);
    chk("model_appb", aes_model(KB, PB), CB);
    chk("model_zero", aes_model('0, '0), CZ);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 C.1 with exact latency
    bus.out_ready = 1'b1;
    send(K1, P1);
    wait_ov(n);
    chk("c1_latency", 128'(n), 128'(10));
    chk("c1_ct", bus.cipher_text, C1);
    @(posedge clk); #1;

    // Appendix B with state after round 1
    send(KB, PB);
    @(posedge clk); #1;
    chk("appb_round1", dut.state_q, R1B);
    wait_ov(n);
    chk("appb_ct", bus.cipher_text, CB);
    @(posedge clk); #1;

    // All-zero vector under back-pressure, with ignored in_valid
    bus.out_ready = 1'b0;
    send('0, '0);
    wait_ov(n);
    bus.in_valid = 1'b1; bus.key = rnd128(); bus.plain_text = rnd128();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_ct", bus.cipher_text, CZ);
      chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
      chk("stall_out_valid", 128'(bus.out_valid), 128'(1));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_ov", 128'(bus.out_valid), 128'(0));
    chk("stall_ct_kept", bus.cipher_text, CZ);
    @(posedge clk); #1;

    // in_valid held with changing data: accepts 12 cycles apart
    acc_times.delete();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      bus.key = rnd128(); bus.plain_text = rnd128();
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("b2b_count", 128'(acc_times.size() >= 4), 128'(1));
    for (int i = 1; i < acc_times.size(); i++)
      chk("b2b_gap", 128'(acc_times[i] - acc_times[i-1]), 128'(12));

    // Reset mid-round, then a clean C.1
    send(K1, P1);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_ov", 128'(bus.out_valid), 128'(0));
    send(K1, P1);
    wait_ov(n);
    chk("post_reset_latency", 128'(n), 128'(10));
    chk("post_reset_ct", bus.cipher_text, C1);
    @(posedge clk); #1;

    // Randomised blocks with random in_valid gaps and out_ready stalls
    target = n_acc + 1000;
    guard = 0;
    while (n_acc < target && guard < 40000) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.key = rnd128(); bus.plain_text = rnd128();
      @(posedge clk); #1;
      guard++;
    end
    chk("rand_accepts", 128'(n_acc >= target), 128'(1));
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("drain_idle", 128'(outst), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
